// File: rtl/xs3_serial_enc.sv
// Bit-serial BCD-to-excess-3 encoder: a small digit FIFO feeds a shifter that adds 3
// with a bit-serial adder and emits each XS3 code LSB-first over a valid/ready link.
module xs3_serial_enc #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       bcd_in,
    input  logic             ser_ready,
    output logic             ser_valid,
    output logic             ser_out,
    output logic             ser_first,
    output logic             ser_last,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] digit_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [3:0]  K  = 4'b0011;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [3:0]    sreg;
    logic [1:0]    idx;
    logic          carry;

    logic          fifo_empty;
    logic          accept;
    logic          bcd_ok;
    logic          push;
    logic          pop;
    logic          bit_adv;
    logic          digit_done;
    logic [3:0]    head;
    logic [1:0]    idx_nxt;
    logic          carry_nxt;

    assign fifo_empty = (count == '0);
    assign in_ready   = (count != CW'(FIFO_DEPTH));
    assign accept     = in_valid && in_ready;
    assign bcd_ok     = (bcd_in <= 4'd9);
    assign push       = accept && bcd_ok;
    assign bit_adv    = (state == SHIFT) && ser_ready;
    assign digit_done = bit_adv && (idx == 2'd3);
    assign pop        = !fifo_empty && ((state == IDLE) || digit_done);
    assign head       = mem[rd_ptr];
    assign idx_nxt    = idx + 2'd1;
    // Majority of digit bit, constant bit and carry; carry out of bit 3 is never used.
    assign carry_nxt  = (sreg[idx] & K[idx]) | (sreg[idx] & carry) | (K[idx] & carry);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bcd_in;
        end
    end

    // FIFO pointers and occupancy; a full FIFO refuses pushes so push/pop never overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && !bcd_ok) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    // Shifter FSM; serial outputs are registered, so each update precomputes the next bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            ser_valid <= 1'b0;
            ser_out   <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
            digit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= SHIFT;
                        sreg      <= head;
                        idx       <= 2'd0;
                        carry     <= 1'b0;
                        ser_valid <= 1'b1;
                        ser_out   <= head[0] ^ K[0];
                        ser_first <= 1'b1;
                        ser_last  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (digit_done) begin
                        digit_cnt <= digit_cnt + CNT_W'(1);
                        if (pop) begin
                            sreg      <= head;
                            idx       <= 2'd0;
                            carry     <= 1'b0;
                            ser_out   <= head[0] ^ K[0];
                            ser_first <= 1'b1;
                            ser_last  <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            idx       <= 2'd0;
                            carry     <= 1'b0;
                            ser_valid <= 1'b0;
                            ser_out   <= 1'b0;
                            ser_first <= 1'b0;
                            ser_last  <= 1'b0;
                        end
                    end else if (bit_adv) begin
                        idx       <= idx_nxt;
                        carry     <= carry_nxt;
                        ser_out   <= sreg[idx_nxt] ^ K[idx_nxt] ^ carry_nxt;
                        ser_first <= 1'b0;
                        ser_last  <= (idx_nxt == 2'd3);
                    end
                end
                default: begin
                    state     <= IDLE;
                    ser_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xs3_serial_enc.sv
// Directed bench for xs3_serial_enc: table of single digits plus streaming,
// backpressure, invalid-digit and mid-digit reset sequences.
module tb_xs3_serial_enc;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] bcd_in;
    logic       ser_ready;
    logic       ser_valid;
    logic       ser_out;
    logic       ser_first;
    logic       ser_last;
    logic       err;
    logic       err_clr;
    logic [7:0] digit_cnt;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] bcd;
        logic [3:0] xs3;
    } vec_t;

    vec_t vecs [6];

    xs3_serial_enc #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .ser_ready (ser_ready),
        .ser_valid (ser_valid),
        .ser_out   (ser_out),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .err       (err),
        .err_clr   (err_clr),
        .digit_cnt (digit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational XS3 reference.
    function automatic logic [3:0] xs3_ref(input logic [3:0] d);
        return d + 4'd3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Push one digit into an idle encoder and check its four serial bits.
    task automatic run_digit(input logic [3:0] d, input logic [3:0] exp);
        in_valid = 1'b1;
        bcd_in   = d;
        tick();
        in_valid = 1'b0;
        check("lat_no_valid", 32'(ser_valid), 32'd0);
        for (int b = 0; b < 4; b++) begin
            tick();
            check("bit_valid", 32'(ser_valid), 32'd1);
            check("bit_first", 32'(ser_first), 32'(b == 0));
            check("bit_last", 32'(ser_last), 32'(b == 3));
            check("bit_value", 32'(ser_out), 32'(exp[b]));
        end
        tick();
        check("idle_after", 32'(ser_valid), 32'd0);
    endtask

    logic [3:0] nib;
    logic [3:0] seq [5];
    int         gaps;
    int         accepted;
    logic       rdy;
    logic       found;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        bcd_in    = 4'd0;
        ser_ready = 1'b1;
        err_clr   = 1'b0;

        vecs[0] = '{bcd: 4'd0, xs3: 4'b0011};
        vecs[1] = '{bcd: 4'd9, xs3: 4'b1100};
        vecs[2] = '{bcd: 4'd5, xs3: 4'b1000};
        vecs[3] = '{bcd: 4'd2, xs3: 4'b0101};
        vecs[4] = '{bcd: 4'd7, xs3: 4'b1010};
        vecs[5] = '{bcd: 4'd3, xs3: 4'b0110};
        seq[0] = 4'd2; seq[1] = 4'd4; seq[2] = 4'd6; seq[3] = 4'd8; seq[4] = 4'd1;

        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(ser_valid), 32'd0);
        check("rst_out", 32'(ser_out), 32'd0);
        check("rst_first", 32'(ser_first), 32'd0);
        check("rst_last", 32'(ser_last), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", 32'(digit_cnt), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_digit(vecs[i].bcd, vecs[i].xs3);
            check("table_cnt", 32'(digit_cnt), 32'(i + 1));
        end

        // Back-to-back 0..9 must stream 40 contiguous bits.
        gaps = 0;
        fork
            begin
                for (int d = 0; d < 10; d++) begin
                    in_valid = 1'b1;
                    bcd_in   = 4'(d);
                    for (int t = 0; t < 200; t++) begin
                        rdy = in_ready;
                        tick();
                        if (rdy) break;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                found = 1'b0;
                for (int t = 0; t < 20 && !found; t++) begin
                    tick();
                    found = ser_valid;
                end
                check("stream_start", 32'(found), 32'd1);
                for (int s = 0; s < 40; s++) begin
                    if (!ser_valid) gaps++;
                    nib[s % 4] = ser_out;
                    if (s % 4 == 3) check("stream_nib", 32'(nib), 32'(xs3_ref(4'(s / 4))));
                    if (s < 39) tick();
                end
                tick();
            end
        join
        check("stream_gaps", 32'(gaps), 32'd0);
        check("stream_end", 32'(ser_valid), 32'd0);
        check("stream_cnt", 32'(digit_cnt), 32'd16);

        // Backpressure: shifter plus full FIFO hold five digits.
        ser_ready = 1'b0;
        accepted  = 0;
        in_valid  = 1'b1;
        for (int t = 0; t < 10; t++) begin
            bcd_in = (accepted < 5) ? seq[accepted] : 4'd3;
            rdy = in_ready;
            tick();
            if (rdy) accepted++;
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_ready", 32'(in_ready), 32'd0);
        check("bp_hold_valid", 32'(ser_valid), 32'd1);
        check("bp_hold_first", 32'(ser_first), 32'd1);
        check("bp_hold_out", 32'(ser_out), 32'd1);
        ser_ready = 1'b1;
        for (int s = 0; s < 20; s++) begin
            if (s >= 1 && s <= 4) check("bp_ready_rise", 32'(in_ready), 32'(s == 4));
            nib[s % 4] = ser_out;
            if (s % 4 == 3) check("bp_nib", 32'(nib), 32'(xs3_ref(seq[s / 4])));
            tick();
        end
        check("bp_end", 32'(ser_valid), 32'd0);
        check("bp_cnt", 32'(digit_cnt), 32'd21);

        // Invalid digits set err and never reach the link.
        in_valid = 1'b1;
        bcd_in   = 4'b1010;
        tick();
        in_valid = 1'b0;
        check("inv_err", 32'(err), 32'd1);
        check("inv_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        check("inv_no_valid", 32'(ser_valid), 32'd0);
        err_clr  = 1'b1;
        in_valid = 1'b1;
        bcd_in   = 4'b1111;
        tick();
        in_valid = 1'b0;
        check("inv_set_wins", 32'(err), 32'd1);
        tick();
        err_clr = 1'b0;
        check("inv_clr", 32'(err), 32'd0);
        check("inv_cnt", 32'(digit_cnt), 32'd21);
        check("inv_no_valid2", 32'(ser_valid), 32'd0);

        // Reset during bit 2 of digit 7 aborts it.
        in_valid = 1'b1;
        bcd_in   = 4'd7;
        tick();
        in_valid = 1'b0;
        tick();
        check("rm_bit0", 32'(ser_out), 32'd0);
        tick();
        check("rm_bit1", 32'(ser_out), 32'd1);
        tick();
        check("rm_bit2", 32'(ser_out), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_valid", 32'(ser_valid), 32'd0);
        check("rm_cnt", 32'(digit_cnt), 32'd0);
        check("rm_ready", 32'(in_ready), 32'd1);
        run_digit(4'd2, 4'b0101);
        check("rm_cnt_after", 32'(digit_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
